// File: rtl/stream_gain_sat.sv
// Signed AXI-Stream gain stage: two-register pipeline computing round-half-up(sample * GAIN)
// saturated to DW, with a pipelined Wishbone config/status port (GAIN, CTRL, SAT_CNT, SMP_CNT).
module stream_gain_sat #(
  parameter int DW    = 24,
  parameter int GAINW = 18,
  parameter int GAINQ = 16,
  parameter int CFGAW = 32,
  parameter int CFGDW = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DW-1:0]    s_axis_tdata,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  output logic [DW-1:0]    m_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  input  logic             cyc_i,
  input  logic             stb_i,
  input  logic             we_i,
  output logic             ack_o,
  output logic             stall_o,
  input  logic [CFGAW-1:0] addr_i,
  input  logic [CFGDW-1:0] data_i,
  output logic [CFGDW-1:0] data_o
);

  localparam int PW = DW + GAINW;
  localparam int RW = PW + 1;
  localparam logic [DW-1:0]          SAT_POS  = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0]          SAT_NEG  = {1'b1, {(DW-1){1'b0}}};
  localparam logic signed [RW-1:0]   MAX_R    = RW'(SAT_POS);
  localparam logic signed [RW-1:0]   MIN_R    = -MAX_R - RW'(1);
  localparam logic signed [RW-1:0]   RND      = RW'(1) << (GAINQ - 1);
  localparam logic [GAINW-1:0]       GAIN_ONE = GAINW'(1) << GAINQ;

  // Handshake: a beat moves on either stream side when valid && ready at a rising edge.
  // Both stages advance together on en; with en low everything (including tdata) holds.
  logic en;
  logic req, wr, clr;

  logic [GAINW-1:0]       gain_q;
  logic                   bypass_q;
  logic [31:0]            sat_cnt_q, sat_cnt_d;
  logic [31:0]            smp_cnt_q, smp_cnt_d;
  logic                   ack_q;
  logic [CFGDW-1:0]       rdata_q, rdata_d;

  logic                   s1_valid_q, s1_bypass_q;
  logic signed [PW-1:0]   s1_prod_q, prod_d;
  logic [DW-1:0]          s1_raw_q;
  logic                   out_valid_q;
  logic [DW-1:0]          out_data_q, out_data_d;

  logic signed [RW-1:0]   rnd_sum, r_val;
  logic                   r_hi, r_lo, clip;

  logic unused_bits;
  assign unused_bits = ^{addr_i[CFGAW-1:2], data_i[CFGDW-1:GAINW]};

  assign en            = !out_valid_q || m_axis_tready;
  assign s_axis_tready = en;
  assign m_axis_tvalid = out_valid_q;
  assign m_axis_tdata  = out_data_q;

  assign req     = cyc_i && stb_i;
  assign wr      = req && we_i;
  assign clr     = wr && (addr_i[1:0] == 2'd1) && data_i[1];
  assign ack_o   = ack_q;
  assign data_o  = rdata_q;
  assign stall_o = 1'b0;

  assign prod_d = PW'($signed(s_axis_tdata)) * PW'($signed(gain_q));

  always_comb begin
    rnd_sum = RW'(s1_prod_q) + RND;
    r_val   = rnd_sum >>> GAINQ;
    r_hi    = r_val > MAX_R;
    r_lo    = r_val < MIN_R;
    clip    = !s1_bypass_q && (r_hi || r_lo);
    if (s1_bypass_q)  out_data_d = s1_raw_q;
    else if (r_hi)    out_data_d = SAT_POS;
    else if (r_lo)    out_data_d = SAT_NEG;
    else              out_data_d = r_val[DW-1:0];
  end

  // Clear wins over a same-edge increment.
  always_comb begin
    sat_cnt_d = sat_cnt_q;
    smp_cnt_d = smp_cnt_q;
    if (en && s1_valid_q) begin
      smp_cnt_d = smp_cnt_q + 32'd1;
      if (clip && (sat_cnt_q != 32'hFFFF_FFFF)) sat_cnt_d = sat_cnt_q + 32'd1;
    end
    if (clr) begin
      sat_cnt_d = 32'd0;
      smp_cnt_d = 32'd0;
    end
  end

  always_comb begin
    rdata_d = '0;
    if (req && !we_i) begin
      case (addr_i[1:0])
        2'd0:    rdata_d = {{(CFGDW-GAINW){gain_q[GAINW-1]}}, gain_q};
        2'd1:    rdata_d = CFGDW'(bypass_q);
        2'd2:    rdata_d = CFGDW'(sat_cnt_q);
        default: rdata_d = CFGDW'(smp_cnt_q);
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gain_q   <= GAIN_ONE;
      bypass_q <= 1'b0;
      ack_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      ack_q   <= req;
      rdata_q <= rdata_d;
      if (wr && (addr_i[1:0] == 2'd0)) gain_q   <= data_i[GAINW-1:0];
      if (wr && (addr_i[1:0] == 2'd1)) bypass_q <= data_i[0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_cnt_q <= 32'd0;
      smp_cnt_q <= 32'd0;
    end else begin
      sat_cnt_q <= sat_cnt_d;
      smp_cnt_q <= smp_cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_bypass_q <= 1'b0;
      s1_prod_q   <= '0;
      s1_raw_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (en) begin
      s1_valid_q  <= s_axis_tvalid;
      s1_bypass_q <= bypass_q;
      s1_prod_q   <= prod_d;
      s1_raw_q    <= s_axis_tdata;
      out_valid_q <= s1_valid_q;
      out_data_q  <= out_data_d;
    end
  end

endmodule

// File: tb/tb_stream_gain_sat.sv
// Bench for stream_gain_sat: directed scenarios plus randomized traffic, checked by a
// queue-based scoreboard against an arithmetic reference model.
module tb_stream_gain_sat;
  localparam int DW    = 24;
  localparam int GAINW = 18;
  localparam int GAINQ = 16;
  localparam int CFGAW = 32;
  localparam int CFGDW = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [DW-1:0]    s_tdata = '0;
  logic             s_tvalid = 1'b0;
  logic             s_axis_tready;
  logic [DW-1:0]    m_axis_tdata;
  logic             m_axis_tvalid;
  logic             m_tready = 1'b1;
  logic             cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic             ack_o, stall_o;
  logic [CFGAW-1:0] addr = '0;
  logic [CFGDW-1:0] wdata = '0;
  logic [CFGDW-1:0] data_o;

  stream_gain_sat #(.DW(DW), .GAINW(GAINW), .GAINQ(GAINQ), .CFGAW(CFGAW), .CFGDW(CFGDW)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_tready),
    .cyc_i(cyc), .stb_i(stb), .we_i(we), .ack_o(ack_o), .stall_o(stall_o),
    .addr_i(addr), .data_i(wdata), .data_o(data_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0]    exp_q[$];
  logic [GAINW-1:0] mdl_gain = 18'h10000;
  bit               mdl_bypass = 0;
  longint           mdl_smp = 0;
  longint           mdl_sat = 0;
  bit               rnd_done = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: real-number gain with round-half-up then clamp to the signed DW range.
  function automatic logic [DW-1:0] ref_out(input logic [DW-1:0] d, output bit clipped);
    longint s, g, r, hi, lo;
    logic [63:0] rv;
    clipped = 0;
    if (mdl_bypass) return d;
    s  = longint'($signed(d));
    g  = longint'($signed(mdl_gain));
    hi = (longint'(1) <<< (DW - 1)) - 1;
    lo = -hi - 1;
    r  = (s * g + (longint'(1) <<< (GAINQ - 1))) >>> GAINQ;
    if (r > hi) begin clipped = 1; r = hi; end
    else if (r < lo) begin clipped = 1; r = lo; end
    rv = r;
    return rv[DW-1:0];
  endfunction

  // driver tasks (called at posedge+1)
  task automatic send(input logic [DW-1:0] d);
    bit c;
    int g;
    s_tdata  = d;
    s_tvalid = 1'b1;
    g = 0;
    @(negedge clk);
    while (!s_axis_tready && g < 100) begin @(negedge clk); g++; end
    chk("s_ready_wait", s_axis_tready, 1);
    exp_q.push_back(ref_out(d, c));
    mdl_smp++;
    if (c) mdl_sat++;
    @(posedge clk); #1;
  endtask

  task automatic stop_stream();
    s_tvalid = 1'b0;
  endtask

  task automatic wb_write(input logic [1:0] a, input logic [31:0] d);
    cyc = 1; stb = 1; we = 1; addr = {30'd0, a}; wdata = d;
    @(posedge clk); #1;
    cyc = 0; stb = 0; we = 0;
    chk("wr_ack", ack_o, 1);
    case (a)
      2'd0: mdl_gain = d[GAINW-1:0];
      2'd1: begin
        mdl_bypass = d[0];
        if (d[1]) begin mdl_smp = 0; mdl_sat = 0; end
      end
      default: ;
    endcase
  endtask

  task automatic wb_read(input logic [1:0] a, input logic [31:0] exp, input string nm);
    cyc = 1; stb = 1; we = 0; addr = {30'd0, a};
    @(posedge clk); #1;
    cyc = 0; stb = 0;
    chk({nm, "_ack"}, ack_o, 1);
    chk(nm, data_o, exp);
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 300) begin @(negedge clk); g++; end
    chk("drain_empty", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  // scoreboard monitor: handshake visible at negedge completes at the next posedge
  bit            hold_v = 0;
  logic [DW-1:0] hold_d = '0;
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      chk("s_ready_en", s_axis_tready, (!m_axis_tvalid || m_tready));
      if (hold_v) begin
        chk("stall_valid", m_axis_tvalid, 1);
        chk("stall_data", m_axis_tdata, hold_d);
      end
      if (m_axis_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_out: got %0h expected none", m_axis_tdata);
        end else begin
          chk("m_tdata", m_axis_tdata, exp_q.pop_front());
        end
      end
      hold_v = m_axis_tvalid && !m_tready;
      hold_d = m_axis_tdata;
    end else begin
      hold_v = 0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] v;
    // reset values
    #2;
    chk("rst_m_valid", m_axis_tvalid, 0);
    chk("rst_ack", ack_o, 0);
    chk("rst_data_o", data_o, 0);
    chk("rst_s_ready", s_axis_tready, 1);
    chk("rst_m_tdata", m_axis_tdata, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    wb_read(2'd0, 32'h0001_0000, "gain_reset");
    @(posedge clk); #1;
    chk("ack_one_cycle", ack_o, 0);
    chk("data_o_idle", data_o, 0);
    chk("stall_zero", stall_o, 0);

    // unity gain, latency
    send(24'd1000); stop_stream();
    chk("lat_not_yet", m_axis_tvalid, 0);
    @(posedge clk); #1;
    chk("lat_valid", m_axis_tvalid, 1);
    chk("lat_data", m_axis_tdata, 24'd1000);
    v = -24'sd7;
    send(v); stop_stream();
    drain();
    wb_read(2'd3, 32'(mdl_smp), "smp_cnt_2");
    wb_read(2'd2, 32'(mdl_sat), "sat_cnt_0");

    // back-to-back reads
    cyc = 1; stb = 1; we = 0; addr = 32'd0;
    @(posedge clk); #1;
    addr = 32'd3;
    chk("b2b_ack1", ack_o, 1);
    chk("b2b_gain", data_o, 32'h0001_0000);
    @(posedge clk); #1;
    cyc = 0; stb = 0;
    chk("b2b_ack2", ack_o, 1);
    chk("b2b_smp", data_o, 32'(mdl_smp));
    @(posedge clk); #1;
    chk("b2b_ack_low", ack_o, 0);

    // gain 0.5 and rounding
    wb_write(2'd0, 32'h0000_8000);
    send(24'd1000); send(24'd3); v = -24'sd3; send(v); stop_stream();
    drain();

    // saturation, then clear
    wb_write(2'd0, 32'h0001_FFFF);
    wb_read(2'd0, 32'h0001_FFFF, "gain_rb");
    send(24'h7F_FFFF); send(24'h80_0000); send(24'd100); stop_stream();
    drain();
    wb_read(2'd2, 32'(mdl_sat), "sat_cnt_clip");
    wb_read(2'd1, 32'd0, "ctrl_rd");
    wb_write(2'd1, 32'h2);
    wb_read(2'd2, 32'd0, "sat_after_clr");
    wb_read(2'd3, 32'd0, "smp_after_clr");
    wb_write(2'd2, 32'h1234);
    wb_read(2'd2, 32'd0, "sat_ro");

    // backpressure ramp
    wb_write(2'd0, 32'h0001_0000);
    fork
      begin
        for (int i = 0; i < 30; i++) begin
          @(posedge clk); #1;
          m_tready = (i < 10) ? (i % 2 == 0) : (i < 15) ? 1'b0 : (i % 2 == 0);
        end
        m_tready = 1'b1;
      end
      begin
        for (int i = 1; i <= 8; i++) send(DW'(i));
        stop_stream();
      end
    join
    drain();
    wb_read(2'd3, 32'(mdl_smp), "smp_ramp");

    // bypass, then mid-stream gain change
    wb_write(2'd0, 32'h0001_FFFF);
    wb_write(2'd1, 32'h1);
    send(24'h7F_FFFF); stop_stream();
    drain();
    wb_read(2'd2, 32'(mdl_sat), "sat_bypass");
    wb_read(2'd1, 32'd1, "ctrl_bypass");
    wb_write(2'd1, 32'h0);
    wb_write(2'd0, 32'h0001_0000);
    send(24'd5); stop_stream();
    wb_write(2'd0, 32'h0002_0000);
    wb_read(2'd0, 32'hFFFE_0000, "gain_neg");
    send(24'd5); stop_stream();
    drain();

    // randomized traffic with random gains and ready
    rnd_done = 0;
    fork
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          m_tready = ($urandom_range(0, 3) != 0);
        end
        m_tready = 1'b1;
      end
      begin
        for (int i = 0; i < 80; i++) begin
          if (i % 20 == 0) begin
            stop_stream();
            wb_write(2'd0, 32'($urandom_range(0, (1 << GAINW) - 1)));
          end
          case ($urandom_range(0, 5))
            0: v = 24'h7F_FFFF;
            1: v = 24'h80_0000;
            default: v = DW'($urandom);
          endcase
          send(v);
          if ($urandom_range(0, 4) == 0) begin
            stop_stream();
            @(posedge clk); #1;
          end
        end
        stop_stream();
        rnd_done = 1;
      end
    join
    drain();
    wb_read(2'd3, 32'(mdl_smp), "smp_random");
    wb_read(2'd2, 32'(mdl_sat), "sat_random");

    // asynchronous reset with samples in flight
    wb_write(2'd0, 32'h0000_4000);
    send(24'd11); send(24'd22); stop_stream();
    chk("inflight_valid", m_axis_tvalid, 1);
    #2 rst_n = 1'b0;
    #1 chk("async_drop", m_axis_tvalid, 0);
    exp_q.delete();
    mdl_gain = 18'h10000; mdl_bypass = 0; mdl_smp = 0; mdl_sat = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_valid", m_axis_tvalid, 0);
    wb_read(2'd0, 32'h0001_0000, "gain_after_rst");
    wb_read(2'd3, 32'd0, "smp_after_rst");

    repeat (3) @(posedge clk);
    chk("final_queue", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
